// File: rtl/cpu_harvard_mem.sv
// Harvard memory subsystem: byte-addressed instruction fetch port with program-load
// write port, and word-addressed data port with byte-lane masking; both reads pipelined.
module cpu_harvard_mem #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                i_en,
  output logic [INST_W-1:0]   inst,
  output logic                inst_valid,
  output logic                i_err,
  input  logic                prog_en,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [INST_W-1:0]   prog_data,
  input  logic                memEn,
  input  logic                memWrEn,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_err
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned IAW   = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW   = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [INST_W-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  logic              r_i_vld [RD_LATENCY];
  logic              r_i_err [RD_LATENCY];
  logic [INST_W-1:0] r_i_dat [RD_LATENCY];
  logic              r_d_vld [RD_LATENCY];
  logic              r_d_err [RD_LATENCY];
  logic [DATA_W-1:0] r_d_dat [RD_LATENCY];

  logic [ADDR_W-1:0] w_i_idx;
  logic              w_i_inr;
  logic              w_p_inr;
  logic              w_d_inr;
  logic              w_d_rd;
  logic              w_d_wr;
  logic [INST_W-1:0] w_i_rd;
  logic [DATA_W-1:0] w_d_rdd;

  always_comb begin
    w_i_idx = pc >> 2;
    w_i_inr = (w_i_idx < ADDR_W'(IMEM_DEPTH));
    w_p_inr = (prog_addr < ADDR_W'(IMEM_DEPTH));
    w_d_inr = (d_addr < ADDR_W'(DMEM_DEPTH));
    w_d_rd  = memEn && !memWrEn;
    w_d_wr  = memEn && memWrEn;
    w_i_rd  = '0;
    w_d_rdd = '0;
    if (i_en && w_i_inr)
      w_i_rd = r_imem[w_i_idx[IAW-1:0]];
    if (w_d_rd && w_d_inr)
      w_d_rdd = r_dmem[d_addr[DAW-1:0]];
  end

  // Arrays are read combinationally before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (prog_en && w_p_inr)
      r_imem[prog_addr[IAW-1:0]] <= prog_data;
    if (w_d_wr && w_d_inr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (d_wmask[i])
          r_dmem[d_addr[DAW-1:0]][DATA_W-1-8*i -: 8] <= d_wdata[DATA_W-1-8*i -: 8];
      end
    end
  end

  // Idle slots carry zero data so the outputs read 0 whenever no response is present.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        r_i_vld[s] <= 1'b0;
        r_i_err[s] <= 1'b0;
        r_i_dat[s] <= '0;
        r_d_vld[s] <= 1'b0;
        r_d_err[s] <= 1'b0;
        r_d_dat[s] <= '0;
      end
    end else begin
      r_i_vld[0] <= i_en;
      r_i_err[0] <= i_en && !w_i_inr;
      r_i_dat[0] <= w_i_rd;
      r_d_vld[0] <= w_d_rd;
      r_d_err[0] <= memEn && !w_d_inr;
      r_d_dat[0] <= w_d_rdd;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        r_i_vld[s] <= r_i_vld[s-1];
        r_i_err[s] <= r_i_err[s-1];
        r_i_dat[s] <= r_i_dat[s-1];
        r_d_vld[s] <= r_d_vld[s-1];
        r_d_err[s] <= r_d_err[s-1];
        r_d_dat[s] <= r_d_dat[s-1];
      end
    end
  end

  always_comb begin
    inst       = r_i_dat[RD_LATENCY-1];
    inst_valid = r_i_vld[RD_LATENCY-1];
    i_err      = r_i_err[RD_LATENCY-1];
    d_rdata    = r_d_dat[RD_LATENCY-1];
    d_rvalid   = r_d_vld[RD_LATENCY-1];
    d_err      = r_d_err[RD_LATENCY-1];
  end

endmodule

// File: tb/tb_cpu_harvard_mem.sv
// Bench for cpu_harvard_mem: three instances (latency 1, 2, 4) share one stimulus stream
// and are compared against a per-edge response timeline built from the memory rules.
module tb_cpu_harvard_mem;

  localparam int DW = 64;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam int DD = 64;
  localparam int ID = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          i_en;
  logic          prog_en;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          memEn;
  logic          memWrEn;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [7:0]    d_wmask;

  logic [IW-1:0] inst_w [3];
  logic          iv_w   [3];
  logic          ie_w   [3];
  logic [DW-1:0] dr_w   [3];
  logic          dv_w   [3];
  logic          de_w   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_harvard_mem #(
      .DATA_W    (DW),
      .INST_W    (IW),
      .ADDR_W    (AW),
      .DMEM_DEPTH(DD),
      .IMEM_DEPTH(ID),
      .RD_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .i_en      (i_en),
      .inst      (inst_w[g]),
      .inst_valid(iv_w[g]),
      .i_err     (ie_w[g]),
      .prog_en   (prog_en),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .memEn     (memEn),
      .memWrEn   (memWrEn),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_rdata   (dr_w[g]),
      .d_rvalid  (dv_w[g]),
      .d_err     (de_w[g])
    );
  end

  typedef struct packed {
    logic          iv;
    logic          ie;
    logic [IW-1:0] id;
    logic          dv;
    logic          de;
    logic [DW-1:0] dd;
  } rsp_t;

  rsp_t          hist[$];
  int            base;
  logic [IW-1:0] imem_m [ID];
  logic [DW-1:0] dmem_m [DD];
  int            checks;
  int            failures;
  logic [DW-1:0] saved;

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response for the request seen at this edge, then apply this edge's writes.
  task automatic model_update();
    rsp_t        r;
    int unsigned ii;
    logic        rd;
    ii   = pc >> 2;
    rd   = memEn && !memWrEn;
    r    = '0;
    r.iv = i_en;
    r.ie = i_en && (ii >= ID);
    if (i_en && ii < ID) r.id = imem_m[ii];
    r.dv = rd;
    r.de = memEn && (d_addr >= DD);
    if (rd && d_addr < DD) r.dd = dmem_m[d_addr];
    if (prog_en && prog_addr < ID) imem_m[prog_addr] = prog_data;
    if (memEn && memWrEn && d_addr < DD)
      for (int i = 0; i < 8; i++)
        if (d_wmask[i]) dmem_m[d_addr][63-8*i -: 8] = d_wdata[63-8*i -: 8];
    hist.push_back(r);
  endtask

  task automatic check_all();
    rsp_t e;
    int   idx;
    for (int g = 0; g < 3; g++) begin
      idx = hist.size() - lat_of(g);
      e   = '0;
      if (idx >= base) e = hist[idx];
      chk($sformatf("inst_L%0d", lat_of(g)),  64'(inst_w[g]), 64'(e.id));
      chk($sformatf("ivld_L%0d", lat_of(g)),  64'(iv_w[g]),   64'(e.iv));
      chk($sformatf("ierr_L%0d", lat_of(g)),  64'(ie_w[g]),   64'(e.ie));
      chk($sformatf("rdata_L%0d", lat_of(g)), dr_w[g],        e.dd);
      chk($sformatf("rvld_L%0d", lat_of(g)),  64'(dv_w[g]),   64'(e.dv));
      chk($sformatf("derr_L%0d", lat_of(g)),  64'(de_w[g]),   64'(e.de));
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk({tag, "_inst"},  64'(inst_w[g]), 64'd0);
      chk({tag, "_ivld"},  64'(iv_w[g]),   64'd0);
      chk({tag, "_ierr"},  64'(ie_w[g]),   64'd0);
      chk({tag, "_rdata"}, dr_w[g],        64'd0);
      chk({tag, "_rvld"},  64'(dv_w[g]),   64'd0);
      chk({tag, "_derr"},  64'(de_w[g]),   64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    i_en      = 1'b0;
    pc        = '0;
    prog_en   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    memEn     = 1'b0;
    memWrEn   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wmask   = '0;
  endtask

  task automatic dwrite(input int a, input logic [63:0] v, input logic [7:0] m);
    idle();
    memEn = 1'b1; memWrEn = 1'b1; d_addr = 32'(a); d_wdata = v; d_wmask = m;
    step();
  endtask

  task automatic dread(input int a);
    idle();
    memEn = 1'b1; d_addr = 32'(a);
    step();
  endtask

  initial begin
    checks = 0; failures = 0; base = 0;
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;

    for (int w = 0; w < ID; w++) begin
      idle();
      prog_en = 1'b1; prog_addr = 32'(w);
      case (w)
        0:       prog_data = 32'h80200001;
        1:       prog_data = 32'h80400002;
        2:       prog_data = 32'hA8611001;
        3:       prog_data = 32'h0;
        default: prog_data = $urandom;
      endcase
      step();
    end
    for (int w = 0; w < DD; w++)
      dwrite(w, (w == 2) ? 64'h1122334455667788 : {$urandom, $urandom}, 8'hFF);
    idle();
    repeat (3) step();

    // back-to-back fetches, observed on the latency-2 instance
    i_en = 1'b1; pc = 32'd0; step();
    pc = 32'd4; step();
    chk("fetch0_L2", 64'(inst_w[1]), 64'h80200001);
    chk("fetch0_vld_L2", 64'(iv_w[1]), 64'd1);
    pc = 32'd8; step();
    chk("fetch1_L2", 64'(inst_w[1]), 64'h80400002);
    idle(); step();
    chk("fetch2_L2", 64'(inst_w[1]), 64'hA8611001);
    step();
    chk("fetch_end_vld_L2", 64'(iv_w[1]), 64'd0);

    dwrite(1, 64'd5, 8'hFF);
    chk("wr_novld_L1", 64'(dv_w[0]), 64'd0);
    dread(1);
    chk("rd_after_wr_L1", dr_w[0], 64'd5);
    chk("rd_after_wr_vld_L1", 64'(dv_w[0]), 64'd1);

    dwrite(2, 64'hAABBCCDDEE0011FF, 8'b10000001);
    dread(2);
    chk("mask_rd_L1", dr_w[0], 64'hAA223344556677FF);

    dread(64);
    chk("oor_rd_data", dr_w[0], 64'd0);
    chk("oor_rd_err", 64'(de_w[0]), 64'd1);
    chk("oor_rd_vld", 64'(dv_w[0]), 64'd1);
    saved = dmem_m[6];
    dwrite(70, ~saved, 8'hFF);
    chk("oor_wr_err", 64'(de_w[0]), 64'd1);
    chk("oor_wr_vld", 64'(dv_w[0]), 64'd0);
    dread(6);
    chk("oor_wr_noalias", dr_w[0], saved);
    idle(); step();
    chk("err_pulse", 64'(de_w[0]), 64'd0);

    idle();
    prog_en = 1'b1; prog_addr = 32'd3; prog_data = 32'hF0000000;
    i_en = 1'b1; pc = 32'd12;
    step();
    chk("rbw_old", 64'(inst_w[0]), 64'd0);
    prog_en = 1'b0;
    step();
    chk("rbw_new", 64'(inst_w[0]), 64'hF0000000);
    idle();
    repeat (3) step();

    for (int n = 0; n < 400; n++) begin
      i_en      = 1'($urandom_range(0, 1));
      pc        = 32'($urandom_range(0, 72*4 - 1));
      prog_en   = ($urandom_range(0, 3) == 0);
      prog_addr = 32'($urandom_range(0, 70));
      prog_data = $urandom;
      memEn     = 1'($urandom_range(0, 1));
      memWrEn   = 1'($urandom_range(0, 1));
      d_addr    = 32'($urandom_range(0, 70));
      d_wdata   = {$urandom, $urandom};
      d_wmask   = 8'($urandom);
      step();
    end
    idle();
    repeat (5) step();

    // reset in the middle of latency-4 reads
    saved = dmem_m[9];
    dread(9);
    dread(10);
    idle();
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst_hold");
    reset = 1'b1;
    base = hist.size();
    repeat (6) step();
    dread(9);
    chk("persist_L1", dr_w[0], saved);
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
